uart_tx: RTL and testbench

- Serial transmitter, the counterpart of the vumeter's UART receive path. Sends bytes back to the host, e.g. level readback or debug.
- Bytes are accepted over a write handshake into a small internal FIFO.
- Each byte is serialised as 1 start bit, 8 data bits sent MSB first (bit 7 down to bit 0), then 1 stop bit. This matches the frame format the receiver expects.
- Bit timing comes from the board clock, using the same board_freq/baud_rate parameter pair as the rest of the design.

---
 rtl/uart_tx.sv | 178 +++++++++++++++++
 tb/tb_uart_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-buffered UART transmitter: 1 start, 8 data bits MSB first, 1 stop.

module uart_tx #(
    parameter int board_freq = 50000000,
    parameter int baud_rate  = 9600,
    parameter int fifo_depth = 4
) (
    input  logic                          clk_board,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [7:0]                    data_in,
    input  logic                          wr_en,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(fifo_depth):0]   fifo_count
);

    localparam int BIT_TICKS = board_freq / baud_rate;
    localparam int CNT_W     = $clog2(BIT_TICKS);
    localparam int AW        = $clog2(fifo_depth);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(BIT_TICKS - 1);
    localparam logic [AW:0]      DEPTH     = (AW + 1)'(fifo_depth);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem [fifo_depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] tick;
    logic [CNT_W-1:0] tick_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shift;
    logic [7:0]       shift_n;
    logic             tx_n;
    logic             busy_n;

    // Full is judged on the registered count, so a pop on the same edge never frees room for a push.
    assign full       = (count == DEPTH);
    assign empty      = (count == '0);
    assign fifo_count = count;
    assign push       = wr_en && !full;

    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_board) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            busy    <= busy_n;
        end
    end

    always_comb begin
        state_n   = state;
        tick_n    = tick;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx;
        busy_n    = busy;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (enable && !empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    tick_n  = '0;
                    state_n = START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end

            START: begin
                if (tick == LAST_TICK) begin
                    tick_n    = '0;
                    bit_idx_n = 3'd7;
                    state_n   = DATA;
                    tx_n      = shift[7];
                end else begin
                    tick_n = tick + 1'b1;
                end
            end

            DATA: begin
                if (tick == LAST_TICK) begin
                    tick_n = '0;
                    if (bit_idx == 3'd0) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx - 3'd1;
                        tx_n      = shift[bit_idx - 3'd1];
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end

            STOP: begin
                if (tick == LAST_TICK) begin
                    tick_n = '0;
                    // Back-to-back frames: reload straight into START with no idle clock.
                    if (enable && !empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-position model.

module tb_uart_tx;

    localparam int T     = 64;
    localparam int DEPTH = 4;
    localparam int N     = 4096;

    logic       clk_board = 1'b0;
    logic       reset     = 1'b0;
    logic       enable    = 1'b1;
    logic       wr_en     = 1'b0;
    logic [7:0] data_in   = 8'h00;
    logic       tx;
    logic       busy;
    logic       full;
    logic       empty;
    logic [2:0] fifo_count;

    always #5 clk_board = ~clk_board;

    uart_tx #(
        .board_freq(64),
        .baud_rate (1),
        .fifo_depth(DEPTH)
    ) dut (
        .clk_board (clk_board),
        .reset     (reset),
        .enable    (enable),
        .data_in   (data_in),
        .wr_en     (wr_en),
        .tx        (tx),
        .busy      (busy),
        .full      (full),
        .empty     (empty),
        .fifo_count(fifo_count)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus the position (in clocks) inside the current frame.
    logic [7:0] mq[$];
    int         mpos = -1;
    logic [7:0] mcur = 8'h00;
    bit         m_full_pre;

    function automatic logic m_tx();
        int idx;
        if (mpos < 0) return 1'b1;
        idx = mpos / T;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return mcur[8 - idx];
    endfunction

    initial forever begin
        @(posedge clk_board or negedge reset);
        if (!reset) begin
            mq.delete();
            mpos = -1;
        end else begin
            m_full_pre = (mq.size() == DEPTH);
            if (mpos < 0 || mpos == 10 * T - 1) begin
                if (enable && mq.size() != 0) begin
                    mcur = mq.pop_front();
                    mpos = 0;
                end else begin
                    mpos = -1;
                end
            end else begin
                mpos++;
            end
            if (wr_en && !m_full_pre) mq.push_back(data_in);
        end
    end

    initial forever begin
        @(posedge clk_board);
        #2;
        if (cmp_on) begin
            chk("tx", tx, m_tx());
            chk("busy", busy, mpos >= 0);
            chk("fifo_count", fifo_count, mq.size());
            chk("full", full, mq.size() == DEPTH);
            chk("empty", empty, mq.size() == 0);
        end
    end

    logic       s_wr [N];
    logic       s_en [N];
    logic [7:0] s_d  [N];
    logic       l_tx [N];
    logic       l_busy [N];
    logic       l_empty [N];
    logic       l_full [N];
    logic [2:0] l_cnt [N];

    task automatic clear_sched();
        for (int i = 0; i < N; i++) begin
            s_wr[i] = 1'b0;
            s_en[i] = 1'b1;
            s_d[i]  = 8'h00;
        end
    endtask

    // Inputs for step c are sampled by edge c; log[c] holds the outputs just after that edge.
    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            wr_en   = s_wr[c];
            data_in = s_d[c];
            enable  = s_en[c];
            @(posedge clk_board);
            #2;
            l_tx[c]    = tx;
            l_busy[c]  = busy;
            l_empty[c] = empty;
            l_full[c]  = full;
            l_cnt[c]   = fifo_count;
        end
        wr_en = 1'b0;
    endtask

    function automatic logic [9:0] frame_at(input int s);
        logic [9:0] f;
        f[9] = l_tx[s + T / 2];
        for (int i = 0; i < 8; i++) f[8 - i] = l_tx[s + T / 2 + T * (i + 1)];
        f[0] = l_tx[s + T / 2 + 9 * T];
        return f;
    endfunction

    function automatic int first_low(input int n);
        for (int i = 0; i < n; i++) if (l_tx[i] == 1'b0) return i;
        return -1;
    endfunction

    function automatic int busy_ones(input int n);
        int k = 0;
        for (int i = 0; i < n; i++) if (l_busy[i]) k++;
        return k;
    endfunction

    function automatic int tx_lows(input int n);
        int k = 0;
        for (int i = 0; i < n; i++) if (!l_tx[i]) k++;
        return k;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state and idle line
        repeat (10) @(negedge clk_board);
        reset = 1'b1;
        @(posedge clk_board);
        #2;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", fifo_count, 0);
        cmp_on = 1;
        clear_sched();
        capture(500);
        chk("idle_lows", tx_lows(500), 0);

        // 2: single 0xAA frame
        clear_sched();
        s_wr[0] = 1'b1; s_d[0] = 8'hAA;
        capture(700);
        chk("t2_latency", first_low(700), 1);
        chk("t2_frame", frame_at(1), 10'h155);
        chk("t2_busy_len", busy_ones(700), 640);
        chk("t2_busy_last", l_busy[640], 1);
        chk("t2_busy_off", l_busy[641], 0);

        // 3: back-to-back 0xAA, 0x55
        clear_sched();
        s_wr[0] = 1'b1; s_d[0] = 8'hAA;
        s_wr[1] = 1'b1; s_d[1] = 8'h55;
        capture(1400);
        chk("t3_frame1", frame_at(1), 10'h155);
        chk("t3_frame2", frame_at(641), 10'h0AB);
        chk("t3_stop_end", l_tx[640], 1);
        chk("t3_no_gap", l_tx[641], 0);
        chk("t3_empty", l_empty[641], 1);
        chk("t3_busy_len", busy_ones(1400), 1280);

        // 4: overfill, 0x06 dropped
        clear_sched();
        for (int k = 0; k < 6; k++) begin
            s_wr[k] = 1'b1;
            s_d[k]  = 8'(k + 1);
        end
        capture(3300);
        chk("t4_full", l_full[4], 1);
        chk("t4_count4", l_cnt[4], 4);
        chk("t4_drop", l_cnt[5], 4);
        for (int j = 0; j < 5; j++) chk("t4_frame", frame_at(1 + 640 * j), {1'b0, 8'(j + 1), 1'b1});
        chk("t4_idle", l_busy[3201], 0);
        chk("t4_empty", l_empty[3201], 1);

        // 5: reset mid-frame with bytes still queued
        clear_sched();
        s_wr[0] = 1'b1; s_d[0] = 8'hAA;
        s_wr[1] = 1'b1; s_d[1] = 8'h55;
        s_wr[2] = 1'b1; s_d[2] = 8'h0F;
        capture(301);
        #1;
        chk("t5_pre_tx", tx, 0);
        chk("t5_pre_count", fifo_count, 2);
        reset = 1'b0;
        #1;
        chk("t5_async_tx", tx, 1);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_count", fifo_count, 0);
        chk("t5_async_empty", empty, 1);
        repeat (3) @(negedge clk_board);
        reset = 1'b1;
        clear_sched();
        capture(800);
        chk("t5_residual", tx_lows(800), 0);
        chk("t5_busy", busy_ones(800), 0);

        // 6: enable gating
        clear_sched();
        for (int c = 0; c < 100; c++) s_en[c] = 1'b0;
        s_wr[0] = 1'b1; s_d[0] = 8'h3C;
        capture(100);
        chk("t6_held", tx_lows(100), 0);
        chk("t6_count", l_cnt[99], 1);
        clear_sched();
        for (int c = 300; c < 700; c++) s_en[c] = 1'b0;
        capture(700);
        chk("t6_start", first_low(700), 0);
        chk("t6_frame", frame_at(0), 10'h079);
        chk("t6_busy_len", busy_ones(700), 640);
        chk("t6_busy_off", l_busy[640], 0);

        cmp_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
